// File: rtl/rv_muldiv_pkg.sv
// Shared constants, FSM state type and funct3 decode helpers for the RV32M unit.
package rv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv_unit_step.sv
// One iteration of the datapath: shift-add for multiply, restoring
// shift-subtract for divide. acc is the product high half / partial remainder,
// lo is the multiplier (shifting out) / dividend-quotient shift register.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   acc_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   acc_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Combinational single-bit step; acc_in[XLEN] is always 0 entering a multiply step
  always_comb begin
    sum     = acc_in + {1'b0, opnd};
    shifted = {acc_in[XLEN-1:0], lo_in[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    acc_out = acc_in;
    lo_out  = lo_in;
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        acc_out = diff[XLEN:0];
        lo_out  = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = shifted;
        lo_out  = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo_in[0]) begin
        acc_out = {1'b0, sum[XLEN:1]};
        lo_out  = {sum[0], lo_in[XLEN-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[XLEN:1]};
        lo_out  = {acc_in[0], lo_in[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Handshake: a transfer happens on a
// rising edge where valid and ready are both high; the producer holds its
// payload steady while valid is high and ready is low.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [TAG_W-1:0]  tag_q;
  logic              sign_a, sign_b;
  logic [XLEN:0]     acc, acc_nxt;
  logic [XLEN-1:0]   lo, lo_nxt, opnd;

  logic              neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign in_ready  = rst_n && !flush && (state == S_IDLE);
  assign dbg_state = state;

  // Sign flags are only set for signed variants with a negative operand
  assign neg_a    = is_signed_a(funct3) & op_a[XLEN-1];
  assign neg_b    = is_signed_b(funct3) & op_b[XLEN-1];
  assign abs_a    = neg_a ? -op_a : op_a;
  assign abs_b    = neg_b ? -op_b : op_b;
  assign div_zero = is_div(funct3) && (op_b == '0);
  assign div_ovf  = is_div(funct3) && is_signed_a(funct3) && (op_a == MIN_VAL) && (op_b == '1);

  // Results of divide-by-zero and signed overflow, known without iterating
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = is_rem(funct3) ? op_a : '1;
    else          special_res = is_rem(funct3) ? '0 : op_a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div(f3)),
    .acc_in  (acc),
    .lo_in   (lo),
    .opnd    (opnd),
    .acc_out (acc_nxt),
    .lo_out  (lo_nxt)
  );

  // Sign restoration of the unsigned magnitude result
  assign prod     = {acc[XLEN-1:0], lo};
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  assign quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
  assign rem_fix  = sign_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  // Pick the architectural result for the latched funct3
  always_comb begin
    fix_res = '0;
    case (f3)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      F3_REM, F3_REMU:              fix_res = rem_fix;
      default:                      fix_res = '0;
    endcase
  end

  // Control FSM and datapath registers; flush overrides everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3        <= '0;
      tag_q     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc       <= '0;
      lo        <= '0;
      opnd      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            f3     <= funct3;
            tag_q  <= in_tag;
            sign_a <= neg_a;
            sign_b <= neg_b;
            if (div_zero || div_ovf) begin
              result    <= special_res;
              out_tag   <= in_tag;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              acc   <= '0;
              lo    <= abs_a;
              opnd  <= abs_b;
              cnt   <= CNT_INIT;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result    <= fix_res;
          out_tag   <= tag_q;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit with XLEN=32, hand-computed expectations.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Issue one op, wait the given latency, check result, hold, then hand off.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg, input int lat,
                        input logic [31:0] exp_r, input int hold);
    logic early;
    @(negedge clk);
    check({name, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; funct3 = f; op_a = a; op_b = b; in_tag = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, ":ready_after_accept"}, {31'd0, in_ready}, 32'd0);
    early = 1'b0;
    for (int i = 1; i < lat; i++) begin
      if (out_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    check({name, ":early_valid"}, {31'd0, early}, 32'd0);
    check({name, ":out_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ":result"}, result, exp_r);
    check({name, ":out_tag"}, {27'd0, out_tag}, {27'd0, tg});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, ":hold_result"}, result, exp_r);
      check({name, ":hold_tag"}, {27'd0, out_tag}, {27'd0, tg});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ":handoff"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic seen_valid;
    logic seen_busy;

    // reset state
    #2;
    check("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check("rst:result", result, 32'd0);
    check("rst:out_tag", {27'd0, out_tag}, 32'd0);
    check("rst:in_ready", {31'd0, in_ready}, 32'd0);
    check("rst:state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // multiply family
    run_op("mul", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 34, 32'hFFFF_FFEB, 3);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 34, 32'hFFFF_FFFE, 0);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 34, 32'h0000_0000, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 34, 32'hFFFF_FFFF, 0);

    // divide family
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 34, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 34, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd11, 34, 32'd14, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd12, 34, 32'd2, 0);

    // special cases resolved at accept
    run_op("div0", 3'b100, 32'd5, 32'd0, 5'd13, 1, 32'hFFFF_FFFF, 0);
    run_op("remu0", 3'b111, 32'd5, 32'd0, 5'd14, 1, 32'd5, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'h8000_0000, 0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h0000_0000, 0);

    // flush mid-divide, with a competing request during flush
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; in_tag = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("flush:busy_state", {30'd0, dbg_state}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; in_tag = 5'd9;
    #1;
    check("flush:in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush:idle", {30'd0, dbg_state}, 32'd0);
    check("flush:out_valid", {31'd0, out_valid}, 32'd0);
    seen_valid = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
      if (dbg_state != 2'd0) seen_busy = 1'b1;
    end
    check("flush:no_result", {31'd0, seen_valid}, 32'd0);
    check("flush:not_accepted", {31'd0, seen_busy}, 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd12, 34, 32'd12, 0);

    // asynchronous reset mid-operation
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; in_tag = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst:out_valid", {31'd0, out_valid}, 32'd0);
    check("arst:result", result, 32'd0);
    check("arst:out_tag", {27'd0, out_tag}, 32'd0);
    check("arst:in_ready", {31'd0, in_ready}, 32'd0);
    check("arst:state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("arst:no_partial", {31'd0, seen_valid}, 32'd0);

    // back-to-back: each accept lands one cycle after the previous handoff
    run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 5'd1, 34, 32'd14, 0);
    run_op("b2b_remu", 3'b111, 32'd100, 32'd7, 5'd2, 34, 32'd2, 0);
    run_op("b2b_div0", 3'b101, 32'd9, 32'd0, 5'd3, 1, 32'hFFFF_FFFF, 0);
    run_op("b2b_mul", 3'b000, 32'h0001_0000, 32'h0001_0000, 5'd4, 34, 32'h0000_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Multi-cycle RV32M execution unit beside the single-cycle integer ALU in the execute stage.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle, parametrised in XLEN.
- Uses valid/ready handshakes on both sides, a destination tag that passes through, and a pipeline flush input.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8)
- TAG_W, 5, width of passthrough destination tag (rd index)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort in-flight op, drop pending result
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept (IDLE and !flush)
- funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- out_tag  out  TAG_W  tag of the op producing result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; result=0; out_tag=0; iteration counter=0; all datapath registers 0. in_ready=0 while rst_n=0.
- States: IDLE, BUSY, FIXUP, DONE (2-bit encoding).
- Accept: in_valid & in_ready at an edge latches funct3, operands, tag and sign flags; absolute values are taken for signed ops.
  - MULH: both operands signed.
  - MULHSU: op_a signed only.
  - DIV/REM: both signed.
  - Next state is BUSY with counter=XLEN.
- Special cases are decided at accept and go IDLE->DONE directly, out_valid 1 cycle after accept:
  - DIV/DIVU with op_b=0 -> all ones.
  - REM/REMU with op_b=0 -> op_a.
  - DIV with op_a=2^(XLEN-1), op_b=-1 -> op_a.
  - REM with op_a=2^(XLEN-1), op_b=-1 -> 0.
- BUSY:
  - Multiply: shift-add, 2*XLEN-bit product register.
  - Divide: restoring shift-subtract; remainder XLEN+1 bits, quotient XLEN bits.
  - Counter decrements each cycle; at counter==1 next state is FIXUP.
- FIXUP (1 cycle): conditional two's-complement negation.
  - Product is negated if sign_a^sign_b (signed variants).
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - Selects low half (MUL) or high half (MULH*) or quotient/remainder into result.
  - Next state is DONE.
- Latency: out_valid rises XLEN+2 cycles after the accepting edge (34 for XLEN=32).
- DONE: out_valid=1. result/out_tag are held stable until out_valid & out_ready, then IDLE on that edge (out_valid=0).
- in_ready is only high in IDLE: no overlap, so the next accept comes 1 cycle after handoff at earliest.
- flush (synchronous, highest priority): any state -> IDLE next edge. out_valid=0 next cycle. in_ready=0 while flush=1, so a simultaneous in_valid is not accepted. result/out_tag are not cleared.
- rst_n asserted mid-operation: immediate return to reset values; no partial result is ever emitted.
- Wrap-around: MUL returns the low XLEN bits modulo 2^XLEN.
- Unsigned ops ignore sign flags.
- Counter width: $clog2(XLEN)+1.

Decomposition:
- Package rv_muldiv_pkg holds:
  - funct3 constants F3_MUL…F3_REMU.
  - state enum/localparams S_IDLE, S_BUSY, S_FIXUP, S_DONE.
  - helper function is_div(funct3) and is_signed_a/b(funct3).
- Sub-module muldiv_step (combinational, parametrised XLEN) computes one shift-add or shift-subtract iteration. It is instantiated once inside rv_muldiv_unit, which keeps the FSM, counter and registers.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), tag 5 -> after 34 cycles out_valid=1, result=0xFFFFFFEB, out_tag=5; result/out_tag held with out_ready=0 for 3 cycles, handoff clears out_valid.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All after 34 cycles.
- DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Each with out_valid 1 cycle after accept.
- Start DIVU, assert flush at cycle 10 -> IDLE next cycle, out_valid never rises. flush with in_valid same cycle -> not accepted. Then a new MUL 3x4 -> 12 with its own tag.
- Drop rst_n async mid-BUSY (between clock edges) -> outputs zero immediately. Release, then back-to-back ops with out_ready=1 -> each accept follows the previous handoff by exactly 1 cycle.
